// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: access-mode
//               codes, FSM state encoding, default address limit and the
//               request fault check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access-mode codes carried on req_mode / mem_mode
  localparam logic [2:0] MODE_WORD  = 3'd0;
  localparam logic [2:0] MODE_HALF  = 3'd1;
  localparam logic [2:0] MODE_HALFU = 3'd2;
  localparam logic [2:0] MODE_BYTE  = 3'd3;
  localparam logic [2:0] MODE_BYTEU = 3'd4;

  // First invalid byte address: data 0x0000-0x2BFF, stack 0x2C00-0x2FFF
  localparam logic [15:0] ADDR_LIMIT_DEFAULT = 16'h3000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  // A request faults on misalignment, an undefined mode or an address
  // at or beyond the limit.
  function automatic logic access_fault(input logic [2:0]  mode,
                                        input logic [15:0] addr,
                                        input logic [15:0] limit);
    logic bad;
    bad = 1'b0;
    case (mode)
      MODE_WORD:              bad = (addr[1:0] != 2'b00);
      MODE_HALF, MODE_HALFU:  bad = addr[0];
      MODE_BYTE, MODE_BYTEU:  bad = 1'b0;
      default:                bad = 1'b1;
    endcase
    return bad || (addr >= limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane
// Description : Combinational lane logic. Extracts and extends the addressed
//               byte/half of a memory word for loads, and builds the merged
//               word for sub-word stores.
// Ports       : word      in  32  memory word (read data or latched old word)
//               mode      in  3   access mode code
//               addr_lo   in  2   byte offset within the word
//               wdata_lo  in  16  store data (low byte or half used)
//               load_data out 32  extended load result
//               merged    out 32  word with the target lane replaced
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  mode,
  input  logic [1:0]  addr_lo,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[{addr_lo, 3'b000} +: 8];
    w_half = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (mode)
      MODE_HALF:  load_data = {{16{w_half[15]}}, w_half};
      MODE_HALFU: load_data = {16'h0000, w_half};
      MODE_BYTE:  load_data = {{24{w_byte[7]}}, w_byte};
      MODE_BYTEU: load_data = {24'h000000, w_byte};
      default:    load_data = word;
    endcase

    merged = word;
    case (mode)
      MODE_HALF, MODE_HALFU: merged[{addr_lo[1], 4'b0000} +: 16] = wdata_lo;
      MODE_BYTE, MODE_BYTEU: merged[{addr_lo, 3'b000} +: 8]      = wdata_lo[7:0];
      default:               merged = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit between a pipeline and a
//               word-wide data memory. Loads return in 2 cycles, word stores
//               in 2, sub-word stores (read-modify-write) in 3, faulting
//               requests in 1.
// Ports       : clk, rst            clock / async active-high reset
//               req_valid/ready     request handshake (ready only in IDLE)
//               req_we/mode/addr/wdata  request fields
//               resp_valid/rdata/err    one-cycle completion pulse + result
//               mem_addr/wdata/we/mode  word-aligned memory access
//               mem_rdata, mem_error    combinational read data / fault
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [15:0] ADDR_LIMIT  = ADDR_LIMIT_DEFAULT,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error
);

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;

  logic        r_we;
  logic [2:0]  r_mode;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_old;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_fault;
  logic        w_word_store;
  logic [15:0] w_word_addr;
  logic [31:0] w_lane_word;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept     = req_valid && req_ready;
  assign w_fault      = access_fault(req_mode, req_addr, ADDR_LIMIT);
  assign w_word_store = r_we && (r_mode == MODE_WORD);
  assign w_word_addr  = {r_addr[15:2], 2'b00};

  // Loads extract from live read data; MERGE works on the word latched
  // during the read phase of the read-modify-write.
  assign w_lane_word = (r_state == ST_MERGE) ? r_old : mem_rdata;

  lsu_lane u_lane (
    .word      (w_lane_word),
    .mode      (r_mode),
    .addr_lo   (r_addr[1:0]),
    .wdata_lo  (r_wdata[15:0]),
    .load_data (w_load_data),
    .merged    (w_merged)
  );

  assign mem_mode   = MODE_WORD;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Next state and memory-side outputs. All outputs decode from r_state,
  // so an asynchronous reset into IDLE silences the memory port at once,
  // including a write pending in MERGE.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 32'h0;
    mem_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = !rst;
        if (w_accept) begin
          w_next_state = w_fault ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr = w_word_addr;
        if (w_word_store) begin
          mem_we       = 1'b1;
          mem_wdata    = r_wdata;
          w_next_state = ST_RESP;
        end else if (r_we) begin
          w_next_state = ST_MERGE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      ST_MERGE: begin
        mem_addr     = w_word_addr;
        mem_we       = 1'b1;
        mem_wdata    = w_merged;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture and result registers. The result registers only change
  // on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_mode  <= MODE_WORD;
      r_addr  <= 16'h0000;
      r_wdata <= 32'h0;
      r_old   <= 32'h0;
      r_rdata <= RESET_RDATA;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_mode  <= req_mode;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_fault) begin
              r_rdata <= 32'h0;
              r_err   <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (!r_we) begin
            r_rdata <= w_load_data;
            r_err   <= mem_error;
          end else if (w_word_store) begin
            r_rdata <= 32'h0;
            r_err   <= mem_error;
          end else begin
            r_old <= mem_rdata;
          end
        end
        ST_MERGE: begin
          r_rdata <= 32'h0;
          r_err   <= mem_error;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
